// File: rtl/dla_hld_ram_arb_pkg.sv
// Shared types and helpers for the dla_hld_ram port arbiter.
// tag_t is sized for the largest supported requester count (8).
package dla_hld_ram_arb_pkg;

  localparam int unsigned MaxIdW = 3;

  typedef struct packed {
    logic              valid;
    logic [MaxIdW-1:0] id;
    logic              err;
  } tag_t;

  function automatic int unsigned clog2_floor(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dla_hld_ram_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
module dla_hld_ram_rr_arbiter
  import dla_hld_ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdW = clog2_floor(NUM_REQ)
) (
  input  logic               clock,
  input  logic               sclr,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IdW-1:0]     grant_id
);

  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW:0]   cand;
  logic           any;
  logic [IdW-1:0] idx;

  // Descending scan so the candidate closest to the pointer wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (IdW + 1)'(ptr_q) + (IdW + 1)'(k);
      if (cand >= (IdW + 1)'(NUM_REQ)) cand = cand - (IdW + 1)'(NUM_REQ);
      if (req[cand[IdW-1:0]]) begin
        any = 1'b1;
        idx = cand[IdW-1:0];
      end
    end
  end

  always_comb begin
    grant_valid = any & ~sclr;
    grant_id    = idx;
    grant       = '0;
    if (grant_valid) grant = NUM_REQ'(1) << idx;
    ptr_d = ptr_q;
    if (grant_valid) begin
      ptr_d = (idx == IdW'(NUM_REQ - 1)) ? '0 : idx + IdW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (sclr) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dla_hld_ram_port_arbiter.sv
// Shares one logical port of a stitched dla_hld_ram between NUM_REQ requesters,
// routing read responses back through a tag pipe matching the RAM read latency.
module dla_hld_ram_port_arbiter
  import dla_hld_ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned DEPTH        = 512,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned READ_LATENCY = 1,
  localparam int unsigned ADDR = clog2_floor(DEPTH),
  localparam int unsigned ID   = clog2_floor(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     sclr,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_write,
  input  logic [NUM_REQ*ADDR-1:0]  req_address,
  input  logic [NUM_REQ*WIDTH-1:0] req_writedata,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic                     rsp_error,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ADDR-1:0]          ram_address,
  output logic                     ram_read_enable,
  output logic                     ram_write,
  output logic [WIDTH-1:0]         ram_writedata,
  input  logic [WIDTH-1:0]         ram_readdata,
  output logic [1:0]               outstanding
);

  logic            grant_valid;
  logic [ID-1:0]   grant_id;
  logic            sel_write;
  logic [ADDR-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic            in_range;
  logic [ADDR-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [1:0]      pipe_count;
  tag_t            issue_tag, out_tag;

  dla_hld_ram_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .clock      (clock),
    .sclr       (sclr),
    .req        (req_valid),
    .grant      (req_ready),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  always_comb begin
    sel_write = req_write[grant_id];
    sel_addr  = req_address[grant_id*ADDR +: ADDR];
    sel_wdata = req_writedata[grant_id*WIDTH +: WIDTH];
    in_range  = ({1'b0, sel_addr} < (ADDR + 1)'(DEPTH));
  end

  // Address/data hold their last granted value while idle.
  always_ff @(posedge clock) begin
    if (sclr) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_valid) begin
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
  end

  always_comb begin
    ram_address     = sclr ? '0 : (grant_valid ? sel_addr : addr_q);
    ram_writedata   = grant_valid ? sel_wdata : wdata_q;
    ram_write       = grant_valid & sel_write & in_range;
    ram_read_enable = grant_valid & ~sel_write & in_range;
  end

  // Out-of-range reads still enter the pipe so error responses keep ordering.
  always_comb begin
    issue_tag       = '0;
    issue_tag.valid = grant_valid & ~sel_write;
    issue_tag.id    = MaxIdW'(grant_id);
    issue_tag.err   = ~in_range;
  end

  if (READ_LATENCY == 0) begin : g_lat0
    assign out_tag    = issue_tag;
    assign pipe_count = 2'd0;
  end else begin : g_pipe
    tag_t pipe_q [READ_LATENCY];

    always_ff @(posedge clock) begin
      if (sclr) begin
        for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= issue_tag;
        for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    always_comb begin
      pipe_count = '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_count = pipe_count + 2'(pipe_q[i].valid);
    end

    assign out_tag = pipe_q[READ_LATENCY-1];
  end

  always_comb begin
    rsp_valid = '0;
    rsp_error = 1'b0;
    rsp_data  = '0;
    if (out_tag.valid && !sclr) begin
      rsp_valid = NUM_REQ'(1) << out_tag.id;
      rsp_error = out_tag.err;
      rsp_data  = out_tag.err ? '0 : ram_readdata;
    end
  end

  assign outstanding = sclr ? 2'd0 : pipe_count;

endmodule

// File: tb/tb_dla_hld_ram_port_arbiter.sv
// Directed bench for dla_hld_ram_port_arbiter: three instances with behavioural RAMs
// at read latencies 2, 1 and 0.
module tb_dla_hld_ram_port_arbiter;

  logic clk = 1'b0;
  logic sclr;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instance A: 4 requesters, depth 384, latency 2
  logic [3:0]   a_valid, a_ready, a_write, a_rv;
  logic [35:0]  a_addr;
  logic [127:0] a_wdata;
  logic         a_err, a_re, a_we;
  logic [31:0]  a_data, a_ram_wdata, a_rd_q;
  logic [8:0]   a_ram_addr, a_addr_q;
  logic [1:0]   a_out;
  logic [31:0]  mem_a [512];

  dla_hld_ram_port_arbiter #(
    .NUM_REQ(4), .DEPTH(384), .WIDTH(32), .READ_LATENCY(2)
  ) u_a (
    .clock(clk), .sclr(sclr), .req_valid(a_valid), .req_ready(a_ready),
    .req_write(a_write), .req_address(a_addr), .req_writedata(a_wdata),
    .rsp_valid(a_rv), .rsp_error(a_err), .rsp_data(a_data),
    .ram_address(a_ram_addr), .ram_read_enable(a_re), .ram_write(a_we),
    .ram_writedata(a_ram_wdata), .ram_readdata(a_rd_q), .outstanding(a_out)
  );

  always @(posedge clk) begin
    if (a_we) mem_a[a_ram_addr] <= a_ram_wdata;
    a_addr_q <= a_ram_addr;
    a_rd_q   <= mem_a[a_addr_q];
  end

  // Instance B: 2 requesters, depth 512, latency 1
  logic [1:0]  b_valid, b_ready, b_write, b_rv;
  logic [17:0] b_addr;
  logic [63:0] b_wdata;
  logic        b_err, b_re, b_we;
  logic [31:0] b_data, b_ram_wdata, b_rd_q;
  logic [8:0]  b_ram_addr;
  logic [1:0]  b_out;
  logic [31:0] mem_b [512];

  dla_hld_ram_port_arbiter #(
    .NUM_REQ(2), .DEPTH(512), .WIDTH(32), .READ_LATENCY(1)
  ) u_b (
    .clock(clk), .sclr(sclr), .req_valid(b_valid), .req_ready(b_ready),
    .req_write(b_write), .req_address(b_addr), .req_writedata(b_wdata),
    .rsp_valid(b_rv), .rsp_error(b_err), .rsp_data(b_data),
    .ram_address(b_ram_addr), .ram_read_enable(b_re), .ram_write(b_we),
    .ram_writedata(b_ram_wdata), .ram_readdata(b_rd_q), .outstanding(b_out)
  );

  always @(posedge clk) begin
    if (b_we) mem_b[b_ram_addr] <= b_ram_wdata;
    b_rd_q <= mem_b[b_ram_addr];
  end

  // Instance C: 2 requesters, depth 512, latency 0
  logic [1:0]  c_valid, c_ready, c_write, c_rv;
  logic [17:0] c_addr;
  logic [63:0] c_wdata;
  logic        c_err, c_re, c_we;
  logic [31:0] c_data, c_ram_wdata, c_rd;
  logic [8:0]  c_ram_addr;
  logic [1:0]  c_out;
  logic [31:0] mem_c [512];

  dla_hld_ram_port_arbiter #(
    .NUM_REQ(2), .DEPTH(512), .WIDTH(32), .READ_LATENCY(0)
  ) u_c (
    .clock(clk), .sclr(sclr), .req_valid(c_valid), .req_ready(c_ready),
    .req_write(c_write), .req_address(c_addr), .req_writedata(c_wdata),
    .rsp_valid(c_rv), .rsp_error(c_err), .rsp_data(c_data),
    .ram_address(c_ram_addr), .ram_read_enable(c_re), .ram_write(c_we),
    .ram_writedata(c_ram_wdata), .ram_readdata(c_rd), .outstanding(c_out)
  );

  assign c_rd = mem_c[c_ram_addr];

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  write;
    int          base;
    logic [3:0]  e_ready;
    logic        e_re;
    logic        e_we;
    int          e_addr;
    logic [3:0]  e_rv;
    logic        e_err;
    logic [31:0] e_data;
    int          e_out;
  } vec_t;

  vec_t tbl [22];

  // Requester i of A uses address base+i and write data C000_0000+i.
  task automatic drive_a(input logic [3:0] v, input logic [3:0] w, input int base);
    a_valid = v;
    a_write = w;
    for (int i = 0; i < 4; i++) begin
      a_addr[i*9 +: 9]    = 9'(base + i);
      a_wdata[i*32 +: 32] = 32'(32'hC000_0000 + i);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem_a[i] = 32'(32'h1000 + i);
      mem_b[i] = 32'(32'h2000 + i);
      mem_c[i] = 32'(32'h3000 + i);
    end
    mem_a[5] = 32'hA5;

    //         valid    write    base  ready    re  we  addr rv       err data          out
    tbl[0]  = '{4'b0001, 4'b0000, 5,   4'b0001, 1, 0, 5,   4'b0000, 0, 32'h0,        0};
    tbl[1]  = '{4'b0000, 4'b0000, 0,   4'b0000, 0, 0, 5,   4'b0000, 0, 32'h0,        1};
    tbl[2]  = '{4'b0000, 4'b0000, 0,   4'b0000, 0, 0, 5,   4'b0001, 0, 32'hA5,       1};
    tbl[3]  = '{4'b1111, 4'b0000, 0,   4'b0010, 1, 0, 1,   4'b0000, 0, 32'h0,        0};
    tbl[4]  = '{4'b1111, 4'b0000, 0,   4'b0100, 1, 0, 2,   4'b0000, 0, 32'h0,        1};
    tbl[5]  = '{4'b1111, 4'b0000, 0,   4'b1000, 1, 0, 3,   4'b0010, 0, 32'h1001,     2};
    tbl[6]  = '{4'b1111, 4'b0000, 0,   4'b0001, 1, 0, 0,   4'b0100, 0, 32'h1002,     2};
    tbl[7]  = '{4'b1111, 4'b0000, 0,   4'b0010, 1, 0, 1,   4'b1000, 0, 32'h1003,     2};
    tbl[8]  = '{4'b1111, 4'b0000, 0,   4'b0100, 1, 0, 2,   4'b0001, 0, 32'h1000,     2};
    tbl[9]  = '{4'b1111, 4'b0000, 0,   4'b1000, 1, 0, 3,   4'b0010, 0, 32'h1001,     2};
    tbl[10] = '{4'b1111, 4'b0000, 0,   4'b0001, 1, 0, 0,   4'b0100, 0, 32'h1002,     2};
    tbl[11] = '{4'b0100, 4'b0000, 0,   4'b0100, 1, 0, 2,   4'b1000, 0, 32'h1003,     2};
    tbl[12] = '{4'b0100, 4'b0000, 0,   4'b0100, 1, 0, 2,   4'b0001, 0, 32'h1000,     2};
    tbl[13] = '{4'b0100, 4'b0000, 0,   4'b0100, 1, 0, 2,   4'b0100, 0, 32'h1002,     2};
    tbl[14] = '{4'b0001, 4'b0000, 384, 4'b0001, 0, 0, 384, 4'b0100, 0, 32'h1002,     2};
    tbl[15] = '{4'b0001, 4'b0001, 400, 4'b0001, 0, 0, 400, 4'b0100, 0, 32'h1002,     2};
    tbl[16] = '{4'b0001, 4'b0000, 383, 4'b0001, 1, 0, 383, 4'b0001, 1, 32'h0,        1};
    tbl[17] = '{4'b0001, 4'b0001, 7,   4'b0001, 0, 1, 7,   4'b0000, 0, 32'h0,        1};
    tbl[18] = '{4'b0000, 4'b0000, 0,   4'b0000, 0, 0, 7,   4'b0001, 0, 32'h117F,     1};
    tbl[19] = '{4'b0001, 4'b0000, 7,   4'b0001, 1, 0, 7,   4'b0000, 0, 32'h0,        0};
    tbl[20] = '{4'b0000, 4'b0000, 0,   4'b0000, 0, 0, 7,   4'b0000, 0, 32'h0,        1};
    tbl[21] = '{4'b0000, 4'b0000, 0,   4'b0000, 0, 0, 7,   4'b0001, 0, 32'hC000_0000, 1};

    sclr = 1'b1;
    drive_a(4'b0000, 4'b0000, 0);
    b_valid = '0; b_write = '0; b_addr = '0; b_wdata = '0;
    c_valid = '0; c_write = '0; c_addr = '0; c_wdata = '0;

    // Reset state, with requests present while sclr is high
    repeat (2) @(negedge clk);
    drive_a(4'b1111, 4'b0000, 0);
    #2;
    chk("reset_ready", a_ready, 4'b0000);
    chk("reset_re", a_re, 1'b0);
    chk("reset_we", a_we, 1'b0);
    chk("reset_addr", a_ram_addr, 9'd0);
    chk("reset_rsp", {a_rv, a_err}, 5'b0);
    chk("reset_data", a_data, 32'h0);
    chk("reset_out", a_out, 2'd0);

    @(negedge clk);
    sclr = 1'b0;
    drive_a(4'b0000, 4'b0000, 0);
    #2;
    chk("idle_ready", a_ready, 4'b0000);
    chk("idle_addr", a_ram_addr, 9'd0);
    chk("idle_out", a_out, 2'd0);

    for (int v = 0; v < 22; v++) begin
      @(negedge clk);
      drive_a(tbl[v].valid, tbl[v].write, tbl[v].base);
      #2;
      chk($sformatf("v%0d_ready", v), a_ready, tbl[v].e_ready);
      chk($sformatf("v%0d_re", v), a_re, tbl[v].e_re);
      chk($sformatf("v%0d_we", v), a_we, tbl[v].e_we);
      chk($sformatf("v%0d_addr", v), a_ram_addr, 64'(tbl[v].e_addr));
      chk($sformatf("v%0d_rsp_valid", v), a_rv, tbl[v].e_rv);
      chk($sformatf("v%0d_rsp_error", v), a_err, tbl[v].e_err);
      chk($sformatf("v%0d_rsp_data", v), a_data, tbl[v].e_data);
      chk($sformatf("v%0d_out", v), a_out, 64'(tbl[v].e_out));
    end

    // Reset mid-flight: two reads in the pipe, then sclr
    @(negedge clk);
    drive_a(4'b0011, 4'b0000, 20);
    #2 chk("mf_grant1", a_ready, 4'b0010);
    @(negedge clk);
    #2 chk("mf_grant0", a_ready, 4'b0001);
    chk("mf_out", a_out, 2'd1);
    @(negedge clk);
    sclr = 1'b1;
    drive_a(4'b1111, 4'b0000, 20);
    #2;
    chk("mf_sclr_ready", a_ready, 4'b0000);
    chk("mf_sclr_re", a_re, 1'b0);
    chk("mf_sclr_rsp", a_rv, 4'b0000);
    @(negedge clk);
    sclr = 1'b0;
    drive_a(4'b0000, 4'b0000, 0);
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("mf_after%0d_rsp", k), a_rv, 4'b0000);
      chk($sformatf("mf_after%0d_out", k), a_out, 2'd0);
      @(negedge clk);
    end
    drive_a(4'b1111, 4'b0000, 0);
    #2 chk("mf_ptr_zero", a_ready, 4'b0001);
    @(negedge clk);
    drive_a(4'b0000, 4'b0000, 0);

    // Latency 1 interleave: W(r0,@10,0x11), R(r1,@10), R(r0,@11)
    b_valid = 2'b01; b_write = 2'b01; b_addr[8:0] = 9'd10; b_wdata[31:0] = 32'h11;
    #2;
    chk("il_w_ready", b_ready, 2'b01);
    chk("il_w_we", b_we, 1'b1);
    chk("il_w_addr", b_ram_addr, 9'd10);
    @(negedge clk);
    b_valid = 2'b10; b_write = 2'b00; b_addr[17:9] = 9'd10;
    #2;
    chk("il_r1_ready", b_ready, 2'b10);
    chk("il_r1_re", b_re, 1'b1);
    chk("il_r1_out", b_out, 2'd0);
    @(negedge clk);
    b_valid = 2'b01; b_write = 2'b00; b_addr[8:0] = 9'd11;
    #2;
    chk("il_r0_ready", b_ready, 2'b01);
    chk("il_rsp1_valid", b_rv, 2'b10);
    chk("il_rsp1_data", b_data, 32'h11);
    chk("il_out_peak", b_out, 2'd1);
    @(negedge clk);
    b_valid = 2'b00;
    #2;
    chk("il_rsp0_valid", b_rv, 2'b01);
    chk("il_rsp0_data", b_data, 32'h200B);
    chk("il_out_hold", b_out, 2'd1);
    @(negedge clk);
    #2;
    chk("il_drain_rsp", b_rv, 2'b00);
    chk("il_drain_out", b_out, 2'd0);

    // Latency 0: response in the grant cycle
    @(negedge clk);
    c_valid = 2'b01; c_addr[8:0] = 9'd0;
    #2;
    chk("l0_a0_re", c_re, 1'b1);
    chk("l0_a0_rsp", c_rv, 2'b01);
    chk("l0_a0_data", c_data, 32'h3000);
    @(negedge clk);
    c_valid = 2'b10; c_addr[17:9] = 9'd511;
    #2;
    chk("l0_a511_rsp", c_rv, 2'b10);
    chk("l0_a511_err", c_err, 1'b0);
    chk("l0_a511_data", c_data, 32'h31FF);
    @(negedge clk);
    c_valid = 2'b00;
    #2 chk("l0_idle_rsp", c_rv, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
